// File: rtl/pe_pkg.sv
// Shared types and constants for the streaming conv MAC processing element.
package pe_pkg;

    typedef enum logic [1:0] {
        ACT_NONE     = 2'd0,
        ACT_RELU     = 2'd1,
        ACT_CLIP     = 2'd2,
        ACT_NONE_ALT = 2'd3
    } act_mode_e;

    typedef enum logic [1:0] {
        CFG_BIAS  = 2'd0,
        CFG_SCALE = 2'd1,
        CFG_SHIFT = 2'd2,
        CFG_NONE  = 2'd3
    } cfg_sel_e;

    typedef enum logic [2:0] {
        ST_ACCUM = 3'd0,
        ST_BIAS  = 3'd1,
        ST_SCALE = 3'd2,
        ST_ACT   = 3'd3,
        ST_OUT   = 3'd4
    } state_e;

    localparam int INT8_MIN = -128;
    localparam int INT8_MAX = 127;

endpackage

// File: rtl/pe_requant_lane.sv
// One output channel of the post-accumulation pipeline:
// bias add (saturating) -> scale with round-half-up shift -> activation -> output clamp.
module pe_requant_lane
    import pe_pkg::*;
#(
    parameter int pDATA_WIDTH  = 8,
    parameter int pACC_WIDTH   = 32,
    parameter int pSCALE_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           en_bias,
    input  logic                           en_scale,
    input  logic                           en_act,
    input  logic signed [pACC_WIDTH-1:0]   acc,
    input  logic signed [31:0]             bias,
    input  logic        [pSCALE_WIDTH-1:0] scale,
    input  logic        [4:0]              shift,
    input  act_mode_e                      act_mode,
    input  logic        [pDATA_WIDTH-1:0]  clip_val,
    output logic signed [pDATA_WIDTH-1:0]  data,
    output logic                           bias_sat
);

    localparam int BW = ((pACC_WIDTH > 32) ? pACC_WIDTH : 32) + 1;
    localparam int PW = pACC_WIDTH + pSCALE_WIDTH + 1;
    localparam int RW = PW + 1;

    localparam logic signed [BW-1:0] B_MAX = (BW'(1) <<< (pACC_WIDTH - 1)) - BW'(1);
    localparam logic signed [BW-1:0] B_MIN = -B_MAX - BW'(1);

    localparam int O_MAX_I = (pDATA_WIDTH == 8) ? INT8_MAX : (2 ** (pDATA_WIDTH - 1) - 1);
    localparam int O_MIN_I = (pDATA_WIDTH == 8) ? INT8_MIN : -(2 ** (pDATA_WIDTH - 1));
    localparam logic signed [RW-1:0] O_MAX = RW'(O_MAX_I);
    localparam logic signed [RW-1:0] O_MIN = RW'(O_MIN_I);

    logic signed [pACC_WIDTH-1:0]  b_q, b_d;
    logic signed [RW-1:0]          r_q, r_d;
    logic signed [pDATA_WIDTH-1:0] data_q, data_d;

    logic signed [BW-1:0] bsum;
    logic signed [RW-1:0] prod;
    logic signed [RW-1:0] rnd;
    logic signed [RW-1:0] act_v;
    logic signed [RW-1:0] clip_ext;

    always_comb begin
        bsum     = BW'(acc) + BW'(bias);
        b_d      = b_q;
        bias_sat = 1'b0;
        if (en_bias) begin
            if (bsum > B_MAX) begin
                b_d      = pACC_WIDTH'(B_MAX);
                bias_sat = 1'b1;
            end else if (bsum < B_MIN) begin
                b_d      = pACC_WIDTH'(B_MIN);
                bias_sat = 1'b1;
            end else begin
                b_d = pACC_WIDTH'(bsum);
            end
        end
    end

    // Scale is unsigned; a zero top bit keeps the product signed.
    always_comb begin
        prod = RW'(b_q) * RW'($signed({1'b0, scale}));
        rnd  = (shift != 5'd0) ? (RW'(1) <<< (shift - 5'd1)) : '0;
        r_d  = en_scale ? ((prod + rnd) >>> shift) : r_q;
    end

    always_comb begin
        clip_ext = RW'(clip_val);
        act_v    = r_q;
        if ((act_mode == ACT_RELU || act_mode == ACT_CLIP) && act_v < 0) begin
            act_v = '0;
        end
        if (act_mode == ACT_CLIP && act_v > clip_ext) begin
            act_v = clip_ext;
        end
        if (act_v > O_MAX) begin
            act_v = O_MAX;
        end else if (act_v < O_MIN) begin
            act_v = O_MIN;
        end
        data_d = en_act ? pDATA_WIDTH'(act_v) : data_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            b_q    <= '0;
            r_q    <= '0;
            data_q <= '0;
        end else begin
            b_q    <= b_d;
            r_q    <= r_d;
            data_q <= data_d;
        end
    end

    assign data = data_q;

endmodule

// File: rtl/pe_conv_mac_stream.sv
// Streaming conv PE: accumulates pKERNEL_TAPS beats per window over valid/ready, then
// requantises each output channel through a pe_requant_lane and presents an int8 window.
module pe_conv_mac_stream
    import pe_pkg::*;
#(
    parameter int pDATA_WIDTH      = 8,
    parameter int pIN_CHANNEL      = 4,
    parameter int pOUTPUT_PARALLEL = 8,
    parameter int pKERNEL_TAPS     = 9,
    parameter int pACC_WIDTH       = 32,
    parameter int pSCALE_WIDTH     = 16
) (
    input  logic                                                clk,
    input  logic                                                rst_n,
    input  logic                                                cfg_we,
    input  logic [1:0]                                          cfg_sel,
    input  logic [$clog2(pOUTPUT_PARALLEL)-1:0]                 cfg_idx,
    input  logic [31:0]                                         cfg_data,
    output logic                                                cfg_err,
    input  logic [1:0]                                          act_mode,
    input  logic [pDATA_WIDTH-1:0]                              clip_val,
    input  logic                                                s_valid,
    output logic                                                s_ready,
    input  logic [pDATA_WIDTH*pIN_CHANNEL-1:0]                  s_act,
    input  logic [pDATA_WIDTH*pIN_CHANNEL*pOUTPUT_PARALLEL-1:0] s_wgt,
    output logic                                                m_valid,
    input  logic                                                m_ready,
    output logic [pDATA_WIDTH*pOUTPUT_PARALLEL-1:0]             m_data,
    output logic                                                sat_flag
);

    localparam logic [2:0] S_ACCUM = ST_ACCUM;
    localparam logic [2:0] S_BIAS  = ST_BIAS;
    localparam logic [2:0] S_SCALE = ST_SCALE;
    localparam logic [2:0] S_ACT   = ST_ACT;
    localparam logic [2:0] S_OUT   = ST_OUT;

    localparam int SUM_W = 2 * pDATA_WIDTH + $clog2(pIN_CHANNEL);
    localparam int AW    = ((pACC_WIDTH > SUM_W) ? pACC_WIDTH : SUM_W) + 1;
    localparam int TW    = (pKERNEL_TAPS > 1) ? $clog2(pKERNEL_TAPS) : 1;
    localparam logic [TW-1:0] TAP_LAST = TW'(pKERNEL_TAPS - 1);

    localparam logic signed [AW-1:0] A_MAX = (AW'(1) <<< (pACC_WIDTH - 1)) - AW'(1);
    localparam logic signed [AW-1:0] A_MIN = -A_MAX - AW'(1);

    logic [2:0]                     state_q, state_d;
    logic [TW-1:0]                  tap_q, tap_d;
    logic signed [pACC_WIDTH-1:0]   acc_q   [pOUTPUT_PARALLEL];
    logic signed [pACC_WIDTH-1:0]   acc_d   [pOUTPUT_PARALLEL];
    logic signed [31:0]             bias_q  [pOUTPUT_PARALLEL];
    logic signed [31:0]             bias_d  [pOUTPUT_PARALLEL];
    logic        [pSCALE_WIDTH-1:0] scale_q [pOUTPUT_PARALLEL];
    logic        [pSCALE_WIDTH-1:0] scale_d [pOUTPUT_PARALLEL];
    logic        [4:0]              shift_q [pOUTPUT_PARALLEL];
    logic        [4:0]              shift_d [pOUTPUT_PARALLEL];
    act_mode_e                      mode_q, mode_d;
    logic [pDATA_WIDTH-1:0]         clip_q, clip_d;
    logic                           cfg_err_q, cfg_err_d;
    logic                           sat_q, sat_d;

    logic signed [SUM_W-1:0]        dot     [pOUTPUT_PARALLEL];
    logic signed [AW-1:0]           acc_tot [pOUTPUT_PARALLEL];
    logic signed [pACC_WIDTH-1:0]   acc_sat [pOUTPUT_PARALLEL];
    logic [pOUTPUT_PARALLEL-1:0]    acc_ovf;
    logic [pOUTPUT_PARALLEL-1:0]    lane_bsat;
    logic signed [pDATA_WIDTH-1:0]  lane_data [pOUTPUT_PARALLEL];

    logic beat_fire;
    logic cfg_open;

    assign beat_fire = s_valid && (state_q == S_ACCUM);
    assign cfg_open  = (state_q == S_ACCUM) && (tap_q == '0);

    always_comb begin
        for (int unsigned o = 0; o < pOUTPUT_PARALLEL; o++) begin
            dot[o] = '0;
            for (int unsigned i = 0; i < pIN_CHANNEL; i++) begin
                dot[o] = dot[o]
                    + SUM_W'($signed(s_act[i*pDATA_WIDTH +: pDATA_WIDTH]))
                    * SUM_W'($signed(s_wgt[(o*pIN_CHANNEL+i)*pDATA_WIDTH +: pDATA_WIDTH]));
            end
            acc_tot[o] = AW'(acc_q[o]) + AW'(dot[o]);
            acc_ovf[o] = 1'b0;
            if (acc_tot[o] > A_MAX) begin
                acc_sat[o] = pACC_WIDTH'(A_MAX);
                acc_ovf[o] = 1'b1;
            end else if (acc_tot[o] < A_MIN) begin
                acc_sat[o] = pACC_WIDTH'(A_MIN);
                acc_ovf[o] = 1'b1;
            end else begin
                acc_sat[o] = pACC_WIDTH'(acc_tot[o]);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        tap_d     = tap_q;
        acc_d     = acc_q;
        bias_d    = bias_q;
        scale_d   = scale_q;
        shift_d   = shift_q;
        mode_d    = mode_q;
        clip_d    = clip_q;
        cfg_err_d = 1'b0;
        sat_d     = sat_q;

        case (state_q)
            S_ACCUM: begin
                if (beat_fire) begin
                    acc_d = acc_sat;
                    if (|acc_ovf) begin
                        sat_d = 1'b1;
                    end
                    if (tap_q == '0) begin
                        mode_d = act_mode_e'(act_mode);
                        clip_d = clip_val;
                    end
                    if (tap_q == TAP_LAST) begin
                        tap_d   = '0;
                        state_d = S_BIAS;
                    end else begin
                        tap_d = tap_q + TW'(1);
                    end
                end
            end
            S_BIAS: begin
                if (|lane_bsat) begin
                    sat_d = 1'b1;
                end
                state_d = S_SCALE;
            end
            S_SCALE: state_d = S_ACT;
            S_ACT:   state_d = S_OUT;
            S_OUT: begin
                if (m_ready) begin
                    state_d = S_ACCUM;
                    for (int unsigned o = 0; o < pOUTPUT_PARALLEL; o++) begin
                        acc_d[o] = '0;
                    end
                end
            end
            default: state_d = S_ACCUM;
        endcase

        // Writes only land between windows, so a window never sees half-updated coefficients.
        if (cfg_we && (cfg_sel_e'(cfg_sel) != CFG_NONE)) begin
            if (cfg_open) begin
                case (cfg_sel_e'(cfg_sel))
                    CFG_BIAS:  bias_d[cfg_idx]  = cfg_data;
                    CFG_SCALE: scale_d[cfg_idx] = cfg_data[pSCALE_WIDTH-1:0];
                    CFG_SHIFT: shift_d[cfg_idx] = cfg_data[4:0];
                    default:   ;
                endcase
            end else begin
                cfg_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_ACCUM;
            tap_q     <= '0;
            mode_q    <= ACT_NONE;
            clip_q    <= '0;
            cfg_err_q <= 1'b0;
            sat_q     <= 1'b0;
            for (int unsigned o = 0; o < pOUTPUT_PARALLEL; o++) begin
                acc_q[o]   <= '0;
                bias_q[o]  <= '0;
                scale_q[o] <= pSCALE_WIDTH'(1);
                shift_q[o] <= '0;
            end
        end else begin
            state_q   <= state_d;
            tap_q     <= tap_d;
            mode_q    <= mode_d;
            clip_q    <= clip_d;
            cfg_err_q <= cfg_err_d;
            sat_q     <= sat_d;
            acc_q     <= acc_d;
            bias_q    <= bias_d;
            scale_q   <= scale_d;
            shift_q   <= shift_d;
        end
    end

    for (genvar g = 0; g < pOUTPUT_PARALLEL; g++) begin : g_lane
        pe_requant_lane #(
            .pDATA_WIDTH (pDATA_WIDTH),
            .pACC_WIDTH  (pACC_WIDTH),
            .pSCALE_WIDTH(pSCALE_WIDTH)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .en_bias (state_q == S_BIAS),
            .en_scale(state_q == S_SCALE),
            .en_act  (state_q == S_ACT),
            .acc     (acc_q[g]),
            .bias    (bias_q[g]),
            .scale   (scale_q[g]),
            .shift   (shift_q[g]),
            .act_mode(mode_q),
            .clip_val(clip_q),
            .data    (lane_data[g]),
            .bias_sat(lane_bsat[g])
        );
        assign m_data[g*pDATA_WIDTH +: pDATA_WIDTH] = lane_data[g];
    end

    assign s_ready  = (state_q == S_ACCUM);
    assign m_valid  = (state_q == S_OUT);
    assign cfg_err  = cfg_err_q;
    assign sat_flag = sat_q;

endmodule

// File: tb/tb_pe_conv_mac_stream.sv
// Scoreboard bench for pe_conv_mac_stream: directed windows push hand-computed results,
// a negedge monitor pops and compares on every output handshake.
module tb_pe_conv_mac_stream;

    localparam int W   = 8;
    localparam int IN  = 4;
    localparam int P   = 8;
    localparam int TAPS = 9;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           cfg_we;
    logic [1:0]     cfg_sel;
    logic [2:0]     cfg_idx;
    logic [31:0]    cfg_data;
    logic           cfg_err;
    logic [1:0]     act_mode;
    logic [W-1:0]   clip_val;
    logic           s_valid;
    logic           s_ready;
    logic [W*IN-1:0]   s_act;
    logic [W*IN*P-1:0] s_wgt;
    logic           m_valid;
    logic           m_ready;
    logic [W*P-1:0] m_data;
    logic           sat_flag;

    always #5 clk = ~clk;

    pe_conv_mac_stream #(
        .pDATA_WIDTH     (W),
        .pIN_CHANNEL     (IN),
        .pOUTPUT_PARALLEL(P),
        .pKERNEL_TAPS    (TAPS),
        .pACC_WIDTH      (16),
        .pSCALE_WIDTH    (16)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cfg_we  (cfg_we),
        .cfg_sel (cfg_sel),
        .cfg_idx (cfg_idx),
        .cfg_data(cfg_data),
        .cfg_err (cfg_err),
        .act_mode(act_mode),
        .clip_val(clip_val),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_act   (s_act),
        .s_wgt   (s_wgt),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .sat_flag(sat_flag)
    );

    logic [W*P-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    function automatic logic [63:0] mk(input int a0, input int a1, input int a2, input int a3,
                                       input int a4, input int a5, input int a6, input int a7);
        return {a7[7:0], a6[7:0], a5[7:0], a4[7:0], a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
    endfunction

    // Channel o gets weight v[o] on input channel 0 only; other weights zero.
    function automatic logic [W*IN*P-1:0] wgt_col0(input logic [63:0] v);
        logic [W*IN*P-1:0] w;
        w = '0;
        for (int o = 0; o < P; o++) begin
            w[o*IN*W +: W] = v[o*W +: W];
        end
        return w;
    endfunction

    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                timeout("unexpected_output");
            end else begin
                check("m_data", m_data, exp_q.pop_front());
            end
        end
    end

    task automatic send_beats(input logic [W*IN-1:0] a, input logic [W*IN*P-1:0] w, input int n);
        int guard;
        for (int k = 0; k < n; k++) begin
            guard = 0;
            @(negedge clk);
            s_valid = 1'b1;
            s_act   = a;
            s_wgt   = w;
            while (!s_ready && guard < 64) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 64) begin
                timeout("s_ready_wait");
            end
            @(posedge clk);
        end
    endtask

    task automatic finish_window();
        int lat;
        @(negedge clk);
        s_valid = 1'b0;
        lat = 0;
        while (!m_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, 3);
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 100) begin
            @(posedge clk);
            g++;
        end
        if (g >= 100) begin
            timeout("drain");
        end
    endtask

    task automatic cfg(input logic [1:0] sel, input int idx, input logic [31:0] d, input logic exp_err);
        @(negedge clk);
        s_valid  = 1'b0;
        cfg_we   = 1'b1;
        cfg_sel  = sel;
        cfg_idx  = idx[2:0];
        cfg_data = d;
        @(negedge clk);
        cfg_we = 1'b0;
        check("cfg_err", cfg_err, exp_err);
        @(negedge clk);
        check("cfg_err_pulse", cfg_err, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        s_valid = 1'b0;
        cfg_we  = 1'b0;
        @(negedge clk);
        check("rst_s_ready", s_ready, 1'b1);
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_m_data", m_data, 64'h0);
        check("rst_cfg_err", cfg_err, 1'b0);
        check("rst_sat_flag", sat_flag, 1'b0);
        rst_n = 1'b1;
    endtask

    task automatic run_vals(input logic [63:0] v, input int nz);
        send_beats(32'h0000_0001, wgt_col0(v), nz);
        send_beats('0, '0, TAPS - nz);
        finish_window();
    endtask

    logic [W*IN-1:0]   ones_a;
    logic [W*IN*P-1:0] ones_w;
    logic [63:0]       v1, v2, e36;

    initial begin
        rst_n    = 1'b0;
        cfg_we   = 1'b0;
        cfg_sel  = '0;
        cfg_idx  = '0;
        cfg_data = '0;
        act_mode = 2'd0;
        clip_val = '0;
        s_valid  = 1'b0;
        s_act    = '0;
        s_wgt    = '0;
        m_ready  = 1'b1;
        ones_a   = {IN{8'd1}};
        ones_w   = {IN*P{8'd1}};
        v1       = mk(100, -5, -20, 90, 7, 7, 7, 7);
        v2       = mk(100, -100, -20, 90, 7, 7, 7, 7);
        e36      = mk(36, 36, 36, 36, 36, 36, 36, 36);

        do_reset();

        // identity window
        exp_q.push_back(e36);
        send_beats(ones_a, ones_w, TAPS);
        finish_window();
        drain();

        // per-channel rounding shift
        cfg(2'd1, 0, 32'd3, 1'b0);
        cfg(2'd2, 0, 32'd2, 1'b0);
        cfg(2'd2, 1, 32'd1, 1'b0);
        cfg(2'd3, 0, 32'd99, 1'b0);
        exp_q.push_back(mk(75, -2, -20, 90, 7, 7, 7, 7));
        run_vals(v1, 1);
        drain();
        cfg(2'd1, 0, 32'd1, 1'b0);
        cfg(2'd2, 0, 32'd0, 1'b0);
        cfg(2'd2, 1, 32'd0, 1'b0);

        // activation modes
        act_mode = 2'd1;
        exp_q.push_back(mk(100, 0, 0, 90, 7, 7, 7, 7));
        run_vals(v1, 1);
        drain();
        act_mode = 2'd2;
        clip_val = 8'd60;
        exp_q.push_back(mk(60, 0, 0, 60, 7, 7, 7, 7));
        run_vals(v1, 1);
        drain();

        // output clamp plus a negative bias
        act_mode = 2'd0;
        cfg(2'd0, 4, 32'hFFFF_FFF6, 1'b0);
        exp_q.push_back(mk(127, -128, -60, 127, 11, 21, 21, 21));
        run_vals(v2, 3);
        drain();
        cfg(2'd0, 4, 32'd0, 1'b0);
        check("sat_flag_clear", sat_flag, 1'b0);

        // backpressure
        @(posedge clk);
        #1 m_ready = 1'b0;
        exp_q.push_back(e36);
        send_beats(ones_a, ones_w, TAPS);
        finish_window();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("bp_m_data", m_data, e36);
            check("bp_m_valid", m_valid, 1'b1);
            check("bp_s_ready", s_ready, 1'b0);
        end
        @(posedge clk);
        #1 m_ready = 1'b1;
        drain();

        // config write mid-window is rejected
        exp_q.push_back(e36);
        send_beats(ones_a, ones_w, 3);
        cfg(2'd0, 0, 32'd50, 1'b1);
        send_beats(ones_a, ones_w, TAPS - 3);
        finish_window();
        drain();

        // reset mid-window discards partial sums
        send_beats(ones_a, {IN*P{8'd100}}, 3);
        do_reset();
        exp_q.push_back(e36);
        send_beats(ones_a, ones_w, TAPS);
        finish_window();
        drain();

        // accumulator saturation, sticky flag
        check("sat_flag_pre", sat_flag, 1'b0);
        exp_q.push_back(mk(127, 127, 127, 127, 127, 127, 127, 127));
        send_beats({IN{8'h80}}, {IN*P{8'h80}}, TAPS);
        finish_window();
        drain();
        check("sat_flag_set", sat_flag, 1'b1);
        exp_q.push_back(e36);
        send_beats(ones_a, ones_w, TAPS);
        finish_window();
        drain();
        check("sat_flag_sticky", sat_flag, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
